// File: rtl/bcd_time_of_day_counter.sv
// ---------------------------------------------------------------------------
// bcd_pair_inc
//   Next-value logic for one packed-BCD digit pair (tens [7:4], units [3:0]).
//   Wraps to 0x00 when the value equals MAX; otherwise the units digit counts
//   0..9 and carries into the tens digit.
//   Ports:
//     val    - current packed-BCD value
//     nxt    - value after one increment
//     at_max - val is the terminal count (increment wraps, carry-out)
// ---------------------------------------------------------------------------
module bcd_pair_inc #(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic [7:0] val,
   output logic [7:0] nxt,
   output logic       at_max
);

   always_comb begin
      at_max = (val == MAX);
      if (at_max)
         nxt = 8'h00;
      else if (val[3:0] == 4'd9)
         nxt = {val[7:4] + 4'd1, 4'd0};
      else
         nxt = {val[7:4], val[3:0] + 4'd1};
   end

endmodule

// ---------------------------------------------------------------------------
// bcd_time_of_day_counter
//   Free-running 24-hour clock (HH:MM:SS, packed BCD) with an internal
//   prescaler producing one second every CLK_DIV clock cycles, and a set mode
//   where hours/minutes are bumped by single-cycle pulses.
//   Ports:
//     clk      - system clock, all state on rising edge
//     rst_n    - asynchronous active-low reset
//     set_mode - 1 = set (timekeeping frozen, seconds held at 00), 0 = run
//     inc_hr   - set mode: hours +1 per high cycle (23 -> 00)
//     inc_min  - set mode: minutes +1 per high cycle (59 -> 00, no carry)
//     hr_bcd   - hours   0x00..0x23
//     min_bcd  - minutes 0x00..0x59
//     sec_bcd  - seconds 0x00..0x59
//     sec_tick - registered pulse, high while outputs show a new second
//     day_wrap - registered pulse, high while outputs show the run-mode
//                rollover 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module bcd_time_of_day_counter #(
   parameter int CLK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_mode,
   input  logic       inc_hr,
   input  logic       inc_min,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       sec_tick,
   output logic       day_wrap
);

   localparam int              PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]   PS_LAST = PW'(CLK_DIV - 1);

   // digit pair index: 0 = seconds, 1 = minutes, 2 = hours
   localparam int SEC = 0;
   localparam int MIN = 1;
   localparam int HR  = 2;

   logic [PW-1:0]   ps_cnt;
   logic            tick_q;
   logic [2:0][7:0] cur;
   logic [2:0][7:0] nxt;
   logic [2:0]      at_max;

   assign cur[SEC] = sec_bcd;
   assign cur[MIN] = min_bcd;
   assign cur[HR]  = hr_bcd;

   // Hours terminate at 0x23, so 0x1A..0x1F and 0x24+ are unreachable.
   for (genvar g = 0; g < 3; g++) begin : g_pair
      bcd_pair_inc #(
         .MAX ((g == HR) ? 8'h23 : 8'h59)
      ) u_inc (
         .val    (cur[g]),
         .nxt    (nxt[g]),
         .at_max (at_max[g])
      );
   end

   // Prescaler. The wrap edge registers tick_q, and the time registers act
   // on tick_q one edge later; this keeps the counter compare off the
   // output path and gives the first second CLK_DIV+1 edges after the
   // prescaler leaves 0 (reset release or set-mode exit), then every
   // CLK_DIV edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt <= '0;
         tick_q <= 1'b0;
      end else if (set_mode) begin
         ps_cnt <= '0;
         tick_q <= 1'b0;
      end else if (ps_cnt == PS_LAST) begin
         ps_cnt <= '0;
         tick_q <= 1'b1;
      end else begin
         ps_cnt <= ps_cnt + PW'(1);
         tick_q <= 1'b0;
      end
   end

   // Time registers and status pulses. A tick_q left over from the last
   // run-mode edge is discarded if set mode is entered on this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_bcd   <= 8'h00;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
         if (set_mode) begin
            sec_bcd <= 8'h00;
            if (inc_hr)
               hr_bcd <= nxt[HR];
            if (inc_min)
               min_bcd <= nxt[MIN];
         end else if (tick_q) begin
            sec_bcd  <= nxt[SEC];
            sec_tick <= 1'b1;
            if (at_max[SEC]) begin
               min_bcd <= nxt[MIN];
               if (at_max[MIN]) begin
                  hr_bcd   <= nxt[HR];
                  day_wrap <= at_max[HR];
               end
            end
         end
      end
   end

endmodule

// File: doc/bcd_time_of_day_counter.md
Name: bcd_time_of_day_counter

Overview:
- Free-running 24-hour time-of-day counter for the multimode clock.
- Holds hours, minutes and seconds as packed BCD (tens nibble [7:4], units nibble [3:0]).
- Sits directly upstream of the 24-hour two-digit seven-segment decoder. hr_bcd feeds that decoder unchanged, so its legal code set is exactly 0x00–0x09, 0x10–0x19 and 0x20–0x23.
- Includes an internal 1 Hz prescaler and a set mode in which the user increments hours and minutes from debounced pushbutton pulses.

Parameters:
- CLK_DIV, 100000000, board clock cycles per second tick; minimum 2. Benches use 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_mode  input  1  level; 1 = set mode (timekeeping frozen), 0 = run.
- inc_hr  input  1  single-cycle pulse; increments hours in set mode.
- inc_min  input  1  single-cycle pulse; increments minutes in set mode.
- hr_bcd  output  8  hours, packed BCD, 0x00–0x23.
- min_bcd  output  8  minutes, packed BCD, 0x00–0x59.
- sec_bcd  output  8  seconds, packed BCD, 0x00–0x59.
- sec_tick  output  1  one-cycle pulse, registered, high in the cycle the outputs show a newly incremented second.
- day_wrap  output  1  one-cycle pulse, registered, high in the cycle the outputs show 00:00:00 after a run-mode rollover from 23:59:59.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hr_bcd = min_bcd = sec_bcd = 0x00.
  - sec_tick = day_wrap = 0.
  - Prescaler = 0.
  - Outputs hold these values while rst_n is low.
  - Counting resumes on the first rising edge after rst_n deasserts.
- Prescaler:
  - Counter of width ceil(log2(CLK_DIV)); counts 0..CLK_DIV-1.
  - Internal tick is asserted when the count equals CLK_DIV-1; the counter wraps to 0 on the same edge.
  - Held at 0 while set_mode=1.
- Run mode (set_mode=0): on an internal tick, on the next edge:
  - Seconds units increment. Units 9 → 0 carries into tens. Seconds 59 → 00 carries into minutes.
  - Minutes follow the same rule. Minutes 59 → 00 carries into hours.
  - Hours units 9 → 0 carries into tens. Hours 23 → 00 (units wrap at 3 when tens = 2).
  - sec_tick=1 for that one cycle.
  - day_wrap=1 only for the 23:59:59 → 00:00:00 transition.
  - inc_hr and inc_min are ignored in run mode.
- Set mode (set_mode=1):
  - Seconds are forced to 0x00 on every clock edge while set_mode=1, including the first.
  - inc_hr pulse: hours +1, 0x23 → 0x00. No day_wrap.
  - inc_min pulse: minutes +1, 0x59 → 0x00. No carry into hours.
  - inc_hr and inc_min in the same cycle: both apply independently.
  - sec_tick and day_wrap stay 0.
  - An inc held high for N cycles gives N increments; debouncing and edge-detection are upstream.
- Mode exit: when set_mode falls, the prescaler starts from 0. The first sec_tick appears exactly CLK_DIV+1 edges after the first edge with set_mode=0 (CLK_DIV edges to reach the tick, one edge to register the increment).
- Invariants:
  - No output ever holds a non-BCD nibble.
  - hr_bcd never exceeds 0x23. In particular, 0x1A–0x1F are never produced.
- Reset mid-operation: reset overrides all modes immediately, including mid-prescale and mid-set.
- Implementation: fully synchronous apart from the reset. No combinational path from inputs to outputs.

Test Plan:
- Reset and first tick, CLK_DIV=4:
  - Hold rst_n=0 → outputs 0x00/0x00/0x00, pulses 0.
  - Release rst_n, set_mode=0 → sec_bcd=0x01 with sec_tick=1 on the 5th edge after release.
  - sec_bcd=0x02 four edges later.
- Cascade carries:
  - Count from 00:00:00 to 00:00:59, then one more tick → 00:01:00.
  - Continue to 00:59:59, then one more tick → 01:00:00.
  - From 09:59:59, one tick → 10:00:00 (hr_bcd=0x10, never 0x0A).
- Day rollover: preload via set mode to 23:59 and run 59 s → from 23:59:59, one tick → 00:00:00 with day_wrap=1 and sec_tick=1 for exactly one cycle.
- Set mode:
  - Run to sec=0x37, then set_mode=1 → sec_bcd=0x00 after the next edge.
  - 24 inc_hr pulses starting from hr=0x00 → hr steps through 0x00–0x23 and returns to 0x00, with day_wrap=0 throughout.
  - From min=0x59 with hr=0x05, one inc_min pulse → min=0x00, hr stays 0x05.
- Simultaneous and ignored inputs:
  - In set mode at 0x23:0x59, inc_hr and inc_min in the same cycle → 00:00.
  - In run mode, inc pulses → no change to hr_bcd or min_bcd.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously between clock edges mid-prescale at 12:34:56 → outputs go to 0 before the next edge.
  - After release, the first tick needs the full CLK_DIV period.
